// File: rtl/cone_share_arbiter.sv
// Round-robin scheduler that time-shares one combinational cone among requesters:
// grant, drive the cone from a register, wait the settle interval, sample and return tagged.
module cone_share_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned IN_W          = 5,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ID_W          = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         cone_in,
  input  logic                    cone_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0] cone_in_q, cone_in_d;
  logic            rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;

  // First valid requester searching upward from rr, wrapping modulo NUM_REQ.
  always_comb begin : grant_search
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    cone_in_d  = cone_in_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          cone_in_d          = req_data[gnt_idx*IN_W +: IN_W];
          rsp_id_d           = gnt_idx;
          cnt_d              = CntW'(SETTLE_CYCLES);
          state_d            = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(1)) begin
          rsp_data_d = cone_out;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      cnt_q      <= '0;
      cone_in_q  <= '0;
      rsp_data_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      cone_in_q  <= cone_in_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign cone_in   = cone_in_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_cone_share_arbiter.sv
// Directed bench for cone_share_arbiter: a parity cone model on the default instance and a
// toggling cone output on a SETTLE_CYCLES=3 instance for sample-point checks.
module tb_cone_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [19:0] req_data;
  logic        rsp_ready;

  logic [3:0]  req_ready;
  logic [4:0]  cone_in;
  logic        cone_out;
  logic        rsp_valid, rsp_data, busy;
  logic [1:0]  rsp_id;

  logic [3:0]  req_ready3;
  logic [4:0]  cone_in3;
  logic        cone_out3;
  logic        rsp_valid3, rsp_data3, busy3;
  logic [1:0]  rsp_id3;
  logic        tog = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [4:0] dv [4];
  logic       exp_bit;
  int         exp_id;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  assign cone_out  = ^cone_in;
  assign cone_out3 = tog;

  cone_share_arbiter #(.NUM_REQ(4), .IN_W(5), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cone_in(cone_in), .cone_out(cone_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  cone_share_arbiter #(.NUM_REQ(4), .IN_W(5), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready3),
    .cone_in(cone_in3), .cone_out(cone_out3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data3), .rsp_id(rsp_id3), .busy(busy3)
  );

  function automatic logic cone_f(input logic [4:0] v);
    return ^v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    dv[0] = 5'b00011;
    dv[1] = 5'b00111;
    dv[2] = 5'b10110;
    dv[3] = 5'b11011;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = {dv[3], dv[2], dv[1], dv[0]};
    rsp_ready = 1'b1;

    // Reset state
    smp();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_cone_in", 32'(cone_in), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single request from requester 2
    nxt();
    rst       = 1'b0;
    req_valid = 4'b0100;
    smp();
    chk("t1_ready", 32'(req_ready), 32'h4);
    chk("t1_busy_T", 32'(busy), 32'h0);
    nxt();
    req_valid = '0;
    smp();
    chk("t1_cone_in_T1", 32'(cone_in), 32'h16);
    chk("t1_busy_T1", 32'(busy), 32'h1);
    chk("t1_valid_T1", 32'(rsp_valid), 32'h0);
    nxt();
    smp();
    chk("t1_cone_in_T2", 32'(cone_in), 32'h16);
    chk("t1_valid_T2", 32'(rsp_valid), 32'h0);
    nxt();
    smp();
    chk("t1_valid_T3", 32'(rsp_valid), 32'h1);
    chk("t1_id", 32'(rsp_id), 32'h2);
    chk("t1_data", 32'(rsp_data), 32'(cone_f(dv[2])));
    nxt();
    smp();
    chk("t1_valid_T4", 32'(rsp_valid), 32'h0);
    chk("t1_busy_T4", 32'(busy), 32'h0);

    // Round-robin with all requesters asserted, grants 0,1,2,3,0 four cycles apart
    rst = 1'b1;
    nxt();
    rst       = 1'b0;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_id = n % 4;
      smp();
      chk($sformatf("rr_grant%0d", n), 32'(req_ready), 32'(1 << exp_id));
      nxt();
      if (n == 4) rsp_ready = 1'b0;
      smp();
      chk($sformatf("rr_quiet%0d", n), 32'(req_ready), 32'h0);
      nxt();
      nxt();
      smp();
      chk($sformatf("rr_valid%0d", n), 32'(rsp_valid), 32'h1);
      chk($sformatf("rr_id%0d", n), 32'(rsp_id), 32'(exp_id));
      chk($sformatf("rr_data%0d", n), 32'(rsp_data), 32'(cone_f(dv[exp_id])));
      if (n < 4) nxt();
    end

    // Backpressure: response frozen while rsp_ready is low
    for (int i = 0; i < 5; i++) begin
      nxt();
      smp();
      chk($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_id%0d", i), 32'(rsp_id), 32'h0);
      chk($sformatf("bp_data%0d", i), 32'(rsp_data), 32'(cone_f(dv[0])));
      chk($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
    end
    nxt();
    rsp_ready = 1'b1;
    smp();
    chk("bp_hs_valid", 32'(rsp_valid), 32'h1);
    chk("bp_hs_ready", 32'(req_ready), 32'h0);
    nxt();
    smp();
    chk("bp_next_grant", 32'(req_ready), 32'h2);

    // Dropped request: requester 3 pulses only while busy
    nxt();
    req_valid = 4'b1000;
    smp();
    chk("drop_ready_a", 32'(req_ready), 32'h0);
    nxt();
    smp();
    chk("drop_ready_b", 32'(req_ready), 32'h0);
    nxt();
    smp();
    chk("drop_rsp_id", 32'(rsp_id), 32'h1);
    chk("drop_ready_c", 32'(req_ready), 32'h0);
    nxt();
    req_valid = '0;
    smp();
    chk("drop_idle_ready", 32'(req_ready), 32'h0);
    chk("drop_idle_busy", 32'(busy), 32'h0);
    nxt();
    smp();
    chk("drop_idle_ready2", 32'(req_ready), 32'h0);

    // Mid-operation reset while in SETTLE
    nxt();
    req_valid = 4'b0001;
    smp();
    chk("mr_grant", 32'(req_ready), 32'h1);
    nxt();
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("mr_req_ready", 32'(req_ready), 32'h0);
    chk("mr_cone_in", 32'(cone_in), 32'h0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mr_rsp_data", 32'(rsp_data), 32'h0);
    chk("mr_rsp_id", 32'(rsp_id), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    nxt();
    rst       = 1'b0;
    req_valid = 4'b1010;
    smp();
    chk("mr_regrant", 32'(req_ready), 32'h2);
    chk("mr_no_rsp0", 32'(rsp_valid), 32'h0);
    nxt();
    req_valid = '0;
    smp();
    chk("mr_no_rsp1", 32'(rsp_valid), 32'h0);
    nxt();
    smp();
    chk("mr_no_rsp2", 32'(rsp_valid), 32'h0);
    nxt();
    smp();
    chk("mr_rsp_valid_new", 32'(rsp_valid), 32'h1);
    chk("mr_rsp_id_new", 32'(rsp_id), 32'h1);
    chk("mr_rsp_data_new", 32'(rsp_data), 32'(cone_f(dv[1])));

    // Settle sampling with SETTLE_CYCLES=3 and a toggling cone output
    nxt();
    rst = 1'b1;
    nxt();
    rst       = 1'b0;
    req_valid = 4'b0001;
    smp();
    chk("st_grant", 32'(req_ready3), 32'h1);
    nxt();
    req_valid = '0;
    smp();
    chk("st_valid_T1", 32'(rsp_valid3), 32'h0);
    nxt();
    smp();
    chk("st_valid_T2", 32'(rsp_valid3), 32'h0);
    nxt();
    smp();
    exp_bit = cone_out3;
    chk("st_valid_T3", 32'(rsp_valid3), 32'h0);
    nxt();
    smp();
    chk("st_valid_T4", 32'(rsp_valid3), 32'h1);
    chk("st_id", 32'(rsp_id3), 32'h0);
    chk("st_data", 32'(rsp_data3), 32'(exp_bit));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
